// File: rtl/iq_snap_pkg.sv
// Shared constants and state encoding for the IQ snapshot buffer.
package iq_snap_pkg;
  localparam int SAMPLES_PER_WORD = 16;
  localparam int WORD_W           = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } snap_state_t;
endpackage

// File: rtl/iq_snap_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Reset clears only the read register; the array keeps its contents.
module iq_snap_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] rd_data_r;

  // Write port, no reset on the storage array
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port, holds when not enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {DW{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;
endmodule

// File: rtl/iq_snapshot_buffer.sv
// Captures DEPTH words of packed 1-bit I/Q samples into RAM and freezes them.
// Optional IQ_SNAP_DECIM2_EN: pack only every other valid sample.
module iq_snapshot_buffer
  import iq_snap_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic              i,
  input  logic              q,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       word_cnt,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);
  localparam logic [AW:0] LAST_WORD = (AW+1)'(DEPTH-1);

  snap_state_t       state_r, next_s;
  logic [3:0]        pack_cnt_r;
  logic [WORD_W-1:0] word_r, asm_s;
  logic [AW:0]       word_cnt_r;
  logic              busy_r, done_r;
  logic              accept_s, pack_s, wr_en_s, last_s, arm_entry_s;
`ifdef IQ_SNAP_DECIM2_EN
  logic              phase_r;
`endif

  // Sample acceptance, packing and next-state decode
  always_comb begin
    accept_s = s_valid && ((state_r == ARM) || (state_r == CAPTURE));
`ifdef IQ_SNAP_DECIM2_EN
    pack_s   = accept_s && !phase_r;
`else
    pack_s   = accept_s;
`endif
    wr_en_s  = pack_s && (pack_cnt_r == 4'd15);
    last_s   = wr_en_s && (word_cnt_r == LAST_WORD);
    asm_s    = word_r;
    asm_s[{pack_cnt_r, 1'b0}] = i;
    asm_s[{pack_cnt_r, 1'b1}] = q;
    next_s   = state_r;
    case (state_r)
      IDLE:    next_s = start ? ARM : IDLE;
      ARM:     next_s = accept_s ? CAPTURE : ARM;
      CAPTURE: next_s = last_s ? DONE : CAPTURE;
      DONE:    next_s = start ? ARM : DONE;
      default: next_s = IDLE;
    endcase
    arm_entry_s = (next_s == ARM) && (state_r != ARM);
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      pack_cnt_r <= 4'd0;
      word_r     <= {WORD_W{1'b0}};
      word_cnt_r <= {(AW+1){1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef IQ_SNAP_DECIM2_EN
      phase_r    <= 1'b0;
`endif
    end else begin
      state_r <= next_s;
      busy_r  <= (next_s == ARM) || (next_s == CAPTURE);
      done_r  <= (next_s == DONE);
      if (arm_entry_s) begin
        pack_cnt_r <= 4'd0;
        word_cnt_r <= {(AW+1){1'b0}};
`ifdef IQ_SNAP_DECIM2_EN
        phase_r    <= 1'b0;
`endif
      end else begin
`ifdef IQ_SNAP_DECIM2_EN
        if (accept_s) begin
          phase_r <= ~phase_r;
        end
`endif
        if (pack_s) begin
          pack_cnt_r <= pack_cnt_r + 4'd1;
          word_r     <= asm_s;
        end
        if (wr_en_s) begin
          word_cnt_r <= word_cnt_r + {{AW{1'b0}}, 1'b1};
        end
      end
    end
  end

  iq_snap_ram #(.DW(WORD_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en_s),
    .waddr   (word_cnt_r[AW-1:0]),
    .wdata   (asm_s),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign busy     = busy_r;
  assign done     = done_r;
  assign word_cnt = word_cnt_r;
endmodule

// File: tb/tb_iq_snapshot_buffer.sv
// Directed self-checking bench for iq_snapshot_buffer with DEPTH=4.
module tb_iq_snapshot_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0, i = 1'b0, q = 1'b0, start = 1'b0;
  logic          busy, done;
  logic [AW:0]   word_cnt;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rd_data;
  int            vec_cnt = 0;
  int            err_cnt = 0;

  iq_snapshot_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .i(i), .q(q), .start(start),
    .busy(busy), .done(done), .word_cnt(word_cnt),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic si, input logic sq);
    s_valid = 1'b1; i = si; q = sq;
    step();
    s_valid = 1'b0; i = 1'b0; q = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic read_all(input string tag, input logic [31:0] exp);
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      step();
      rd_en = 1'b0;
      check(tag, rd_data, exp);
    end
    step();
    check({tag, "_hold"}, rd_data, exp);
  endtask

  initial begin
    step(); step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wcnt", {29'd0, word_cnt}, 32'd0);
    check("rst_rdata", rd_data, 32'd0);
    rst = 1'b0;
    step();

`ifdef IQ_SNAP_DECIM2_EN
    arm();
    for (int n = 0; n < 126; n++) sample(n[0] == 1'b0, n[0] == 1'b0);
    check("dec_done_early", {31'd0, done}, 32'd0);
    sample(1'b1, 1'b1);
    check("dec_done", {31'd0, done}, 32'd1);
    check("dec_wcnt", {29'd0, word_cnt}, 32'd4);
    read_all("dec_word", 32'hFFFF_FFFF);
`else
    // Constant i=1, q=0
    arm();
    check("arm_busy", {31'd0, busy}, 32'd1);
    for (int n = 0; n < 63; n++) sample(1'b1, 1'b0);
    check("t1_done_early", {31'd0, done}, 32'd0);
    check("t1_wcnt_early", {29'd0, word_cnt}, 32'd3);
    sample(1'b1, 1'b0);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_wcnt", {29'd0, word_cnt}, 32'd4);
    read_all("t1_word", 32'h5555_5555);

    // Counting pattern i=n[0], q=n[1]; start from DONE re-arms
    arm();
    check("t2_done_drop", {31'd0, done}, 32'd0);
    check("t2_wcnt_clr", {29'd0, word_cnt}, 32'd0);
    for (int n = 0; n < 64; n++) sample(n[0], n[1]);
    check("t2_done", {31'd0, done}, 32'd1);
    read_all("t2_word", 32'hE4E4_E4E4);

    // Sample coincident with start must be excluded
    s_valid = 1'b1; i = 1'b1; q = 1'b1; start = 1'b1;
    step();
    start = 1'b0; s_valid = 1'b0;
    for (int n = 0; n < 64; n++) sample(1'b0, 1'b0);
    check("t3_done", {31'd0, done}, 32'd1);
    read_all("t3_word", 32'h0000_0000);

    // Reset mid-capture, then a clean capture of all ones
    arm();
    for (int n = 0; n < 20; n++) sample(1'b1, 1'b0);
    rst = 1'b1;
    step();
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_done", {31'd0, done}, 32'd0);
    check("t4_rst_wcnt", {29'd0, word_cnt}, 32'd0);
    rst = 1'b0;
    step();
    check("t4_idle_busy", {31'd0, busy}, 32'd0);
    arm();
    for (int n = 0; n < 64; n++) sample(1'b1, 1'b1);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_wcnt", {29'd0, word_cnt}, 32'd4);
    read_all("t4_word", 32'hFFFF_FFFF);

    // Gapped samples with start pulsed mid-capture (ignored)
    arm();
    for (int n = 0; n < 63; n++) begin
      if (n == 30) start = 1'b1;
      sample(n[0], 1'b0);
      start = 1'b0;
      step();
    end
    check("t5_done_early", {31'd0, done}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd1);
    sample(1'b1, 1'b0);
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_wcnt", {29'd0, word_cnt}, 32'd4);
    read_all("t5_word", 32'h4444_4444);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/iq_snapshot_buffer.md
# iq_snapshot_buffer

Captures a fixed-length snapshot of the 1-bit I/Q sample stream coming out of the front-end sample reader (sign bits of the 4 MHz IQ file/ADC stream) and packs it into 32-bit words in an on-chip simple dual-port RAM. It sits directly downstream of the sample source and upstream of the acquisition engine, which reads the frozen snapshot through a synchronous read port once `done` is raised.

## Interface
- `DEPTH`, 1024: snapshot length in 32-bit words (16 samples/word; 1024 words = 16384 samples = 4.096 ms at 4 MHz); power of two, ≥ 2.
- `AW`, $clog2(DEPTH): read-address width.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  sample strobe; `i`/`q` valid when high (may be high any fraction of cycles).
- `i`  in  1  in-phase sign bit.
- `q`  in  1  quadrature sign bit.
- `start`  in  1  one-cycle arm request.
- `busy`  out  1  high in ARM and CAPTURE.
- `done`  out  1  high in DONE; snapshot complete and frozen.
- `word_cnt`  out  AW+1  words written in current/last snapshot.
- `rd_en`  in  1  read enable.
- `rd_addr`  in  AW  word address.
- `rd_data`  out  32  read data, one-cycle latency.

## Operation
- States: IDLE → ARM → CAPTURE → DONE.
- IDLE: `start` → ARM. ARM: first `s_valid` strictly after the `start` cycle → CAPTURE, that sample is sample 0. A sample coincident with `start` is never captured.
- Packing: sample k of a word (k = 0..15) goes to bits [2k] = `i`, [2k+1] = `q`. Pack counter 0..15; on k = 15 the assembled word (including the current sample) is written at write address `word_cnt[AW-1:0]` on the same edge; `word_cnt` increments.
- CAPTURE ends on the edge accepting sample 15 of word DEPTH-1 → DONE. No partial words are ever written.
- DONE: RAM write disabled; `start` → ARM (clears `word_cnt`, pack counter; `done` drops next cycle). IDLE reached only via `rst`.
- `start` in ARM or CAPTURE: ignored.
- `rst` at any time, including mid-capture: state IDLE, counters zero, `busy`=0, `done`=0, `word_cnt`=0, `rd_data`=0. RAM contents are not cleared.
- Reads allowed in any state; contents defined only in DONE. Address ≥ DEPTH impossible (AW bits).

## Timing
- Reset values: `busy` 0, `done` 0, `word_cnt` 0, `rd_data` 0.
- `busy` rises the cycle after `start`.
- `done` rises the cycle after the edge that wrote the last word; a read issued that same cycle of word DEPTH-1 returns the new data on the following cycle.
- `rd_data` updates on the edge after `rd_en`=1; holds its value when `rd_en`=0.
- Continuous `s_valid`: capture takes exactly 16·DEPTH valid samples after ARM exit; no back-pressure, no sample drops.

## Configuration
- `IQ_SNAP_DECIM2_EN` defined: in CAPTURE only the 1st, 3rd, 5th … valid samples (counting sample 0 as the first) are packed; the others are discarded; the decimation phase resets on ARM entry. Snapshot still fills DEPTH words, covering twice the time span.
- Undefined: every valid sample is packed.

## Structure
- Package `iq_snap_pkg`: `SAMPLES_PER_WORD` = 16, `WORD_W` = 32, state enum `snap_state_t` (IDLE, ARM, CAPTURE, DONE).
- Sub-module `iq_snap_ram`: parameterised simple dual-port RAM (one write port, one registered read port, `rst` clears only the read register).

## Test plan
- DEPTH=4, `start`, then 64 continuous samples i=1,q=0 → all four words 0x5555_5555, `done`=1 one cycle after the 64th sample, `word_cnt`=4.
- DEPTH=4, sample n with i=n[0], q=n[1] → each word 0xE4E4_E4E4; reading addr 0..3 gives that value one cycle after each `rd_en`.
- `s_valid` high on the `start` cycle with i=q=1, then i=q=0 → word 0 = 0x0000_0000 (coincident sample excluded).
- `rst` after 20 samples, then `start` and 64 samples of i=q=1 → `busy`/`done` zero during reset, final words all 0xFFFF_FFFF, `word_cnt`=4.
- `start` pulsed mid-capture → ignored, capture ends after the same 64 samples; `start` in DONE → `done`=0 next cycle, new snapshot overwrites.
- With `IQ_SNAP_DECIM2_EN`, 128 samples alternating i=q=1 / i=q=0 → all words 0xFFFF_FFFF, `done` after the 127th sample.
